keypad_entry_ctrl: RTL and testbench

Keypad entry controller: turns the debounced key code from the keypad scanner into numeric parameter writes for the DDS configuration registers. It accumulates decimal digits into a binary value and selects one of four target registers with keys A–D. On `#` it issues a valid/ready write toward the register bank. It sits between the keypad scanner output and the register/configuration bus, and also drives the front-panel display with the entry in progress.

---
 rtl/keypad_entry_ctrl.sv | 154 +++++++++++++++
 tb/tb_keypad_entry_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/keypad_entry_ctrl.sv
// Keypad entry controller: accumulates decimal key presses into a binary value
// and issues a valid/ready register write to one of four targets on '#'.
module keypad_entry_ctrl #(
  parameter int unsigned W      = 32,
  parameter int unsigned DIGITS = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [7:0]   i_key,
  input  logic         i_wr_ready,
  output logic         o_wr_valid,
  output logic [1:0]   o_wr_addr,
  output logic [W-1:0] o_wr_data,
  output logic [W-1:0] o_entry,
  output logic [3:0]   o_digits,
  output logic [1:0]   o_target,
  output logic         o_busy
);

  localparam int unsigned KEY_W  = 8;
  localparam int unsigned DIG_W  = 4;
  localparam int unsigned ADDR_W = 2;

  localparam logic [KEY_W-1:0] KEY_NONE    = 8'hFF;
  localparam logic [KEY_W-1:0] KEY_DIG_MAX = 8'h09;
  localparam logic [KEY_W-1:0] KEY_SEL_A   = 8'h0A;
  localparam logic [KEY_W-1:0] KEY_SEL_D   = 8'h0D;
  localparam logic [KEY_W-1:0] KEY_ENTER   = 8'h10;
  localparam logic [KEY_W-1:0] KEY_CLEAR   = 8'h11;

  typedef enum logic [1:0] {
    S_EMPTY  = 2'd0,
    S_ENTRY  = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [KEY_W-1:0]    key_q;
  logic [W-1:0]        entry_q, entry_d;
  logic [DIG_W-1:0]    digits_q, digits_d;
  logic [ADDR_W-1:0]   target_q, target_d;
  logic                valid_q, valid_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [W-1:0]        wr_data_q, wr_data_d;
  logic                busy_q, busy_d;

  logic                key_ev_c;
  logic                is_digit_c, is_sel_c;
  logic [W-1:0]        digit_val_c;
  logic [ADDR_W-1:0]   sel_val_c;
  logic [W-1:0]        entry_x10_c;

  // One event per press: the code must differ from last cycle's and not be idle.
  always_comb begin
    key_ev_c    = (i_key != key_q) && (i_key != KEY_NONE);
    is_digit_c  = (i_key <= KEY_DIG_MAX);
    is_sel_c    = (i_key >= KEY_SEL_A) && (i_key <= KEY_SEL_D);
    digit_val_c = W'(i_key[3:0]);
    sel_val_c   = ADDR_W'(i_key - KEY_SEL_A);
    entry_x10_c = (entry_q << 3) + (entry_q << 1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_EMPTY;
      key_q     <= KEY_NONE;
      entry_q   <= '0;
      digits_q  <= '0;
      target_q  <= '0;
      valid_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      key_q     <= i_key;
      entry_q   <= entry_d;
      digits_q  <= digits_d;
      target_q  <= target_d;
      valid_q   <= valid_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    entry_d   = entry_q;
    digits_d  = digits_q;
    target_d  = target_q;
    valid_d   = valid_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    case (state_q)
      S_EMPTY: begin
        if (key_ev_c) begin
          if (is_digit_c) begin
            entry_d  = digit_val_c;
            digits_d = DIG_W'(1);
            state_d  = S_ENTRY;
          end else if (is_sel_c) begin
            target_d = sel_val_c;
          end
        end
      end
      S_ENTRY: begin
        if (key_ev_c) begin
          if (is_digit_c) begin
            if (digits_q < DIG_W'(DIGITS)) begin
              entry_d  = entry_x10_c + digit_val_c;
              digits_d = digits_q + DIG_W'(1);
            end
          end else if (is_sel_c) begin
            target_d = sel_val_c;
          end else if (i_key == KEY_CLEAR) begin
            entry_d  = '0;
            digits_d = '0;
            state_d  = S_EMPTY;
          end else if (i_key == KEY_ENTER) begin
            wr_data_d = entry_q;
            wr_addr_d = target_q;
            valid_d   = 1'b1;
            state_d   = S_COMMIT;
          end
        end
      end
      S_COMMIT: begin
        // Keys are discarded here; only the handshake moves us on.
        if (i_wr_ready) begin
          valid_d  = 1'b0;
          entry_d  = '0;
          digits_d = '0;
          state_d  = S_EMPTY;
        end
      end
      default: begin
        state_d = S_EMPTY;
      end
    endcase

    busy_d = (state_d == S_COMMIT);
  end

  assign o_wr_valid = valid_q;
  assign o_wr_addr  = wr_addr_q;
  assign o_wr_data  = wr_data_q;
  assign o_entry    = entry_q;
  assign o_digits   = digits_q;
  assign o_target   = target_q;
  assign o_busy     = busy_q;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Directed self-checking bench for keypad_entry_ctrl; inputs driven and
// outputs sampled on the falling clock edge.
module tb_keypad_entry_ctrl;

  localparam int unsigned W      = 32;
  localparam int unsigned DIGITS = 8;

  logic         clk;
  logic         rst_n;
  logic [7:0]   key;
  logic         wr_ready;
  logic         wr_valid;
  logic [1:0]   wr_addr;
  logic [W-1:0] wr_data;
  logic [W-1:0] entry;
  logic [3:0]   digits;
  logic [1:0]   target;
  logic         busy;

  int errors = 0;
  int checks = 0;

  keypad_entry_ctrl #(.W(W), .DIGITS(DIGITS)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_key      (key),
    .i_wr_ready (wr_ready),
    .o_wr_valid (wr_valid),
    .o_wr_addr  (wr_addr),
    .o_wr_data  (wr_data),
    .o_entry    (entry),
    .o_digits   (digits),
    .o_target   (target),
    .o_busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive a key for one cycle then release it.
  task automatic press(input logic [7:0] k);
    key = k;
    @(negedge clk);
    key = 8'hFF;
    @(negedge clk);
  endtask

  task automatic chk_all_reset(input string tag);
    chk({tag, "_valid"},  32'(wr_valid), 32'd0);
    chk({tag, "_addr"},   32'(wr_addr),  32'd0);
    chk({tag, "_data"},   wr_data,       32'd0);
    chk({tag, "_entry"},  entry,         32'd0);
    chk({tag, "_digits"}, 32'(digits),   32'd0);
    chk({tag, "_target"}, 32'(target),   32'd0);
    chk({tag, "_busy"},   32'(busy),     32'd0);
  endtask

  initial begin
    rst_n    = 1'b1;
    key      = 8'hFF;
    wr_ready = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Select B, enter 1250, commit with ready low.
    press(8'h0B);
    chk("sel_b_target", 32'(target), 32'd1);
    press(8'h01);
    press(8'h02);
    press(8'h05);
    press(8'h00);
    chk("entry_1250", entry, 32'd1250);
    chk("digits_4", 32'(digits), 32'd4);
    key = 8'h10;
    @(negedge clk);
    chk("commit_valid", 32'(wr_valid), 32'd1);
    chk("commit_addr", 32'(wr_addr), 32'd1);
    chk("commit_data", wr_data, 32'd1250);
    chk("commit_busy", 32'(busy), 32'd1);
    key = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(wr_valid), 32'd1);
      chk("hold_data", wr_data, 32'd1250);
    end
    // Keys pressed during COMMIT are discarded.
    press(8'h03);
    press(8'h0D);
    chk("commit_key_entry", entry, 32'd1250);
    chk("commit_key_target", 32'(target), 32'd1);
    chk("commit_key_data", wr_data, 32'd1250);
    chk("commit_key_addr", 32'(wr_addr), 32'd1);
    wr_ready = 1'b1;
    @(negedge clk);
    wr_ready = 1'b0;
    chk("hs_valid", 32'(wr_valid), 32'd0);
    chk("hs_entry", entry, 32'd0);
    chk("hs_digits", 32'(digits), 32'd0);
    chk("hs_busy", 32'(busy), 32'd0);

    // Nine nines: the ninth is dropped.
    for (int i = 0; i < 9; i++) press(8'h09);
    chk("max_entry", entry, 32'd99999999);
    chk("max_digits", 32'(digits), 32'd8);
    // Commit with ready held high: one-cycle COMMIT.
    wr_ready = 1'b1;
    key = 8'h10;
    @(negedge clk);
    chk("fast_valid", 32'(wr_valid), 32'd1);
    chk("fast_data", wr_data, 32'd99999999);
    @(negedge clk);
    chk("fast_done", 32'(wr_valid), 32'd0);
    key = 8'hFF;
    wr_ready = 1'b0;
    @(negedge clk);
    chk("fast_held_key_digits", 32'(digits), 32'd0);

    // Clear keeps target; '#' from EMPTY does nothing.
    press(8'h04);
    press(8'h02);
    chk("entry_42", entry, 32'd42);
    press(8'h11);
    chk("clr_entry", entry, 32'd0);
    chk("clr_digits", 32'(digits), 32'd0);
    chk("clr_target", 32'(target), 32'd1);
    press(8'h10);
    chk("empty_enter_valid", 32'(wr_valid), 32'd0);
    chk("empty_enter_busy", 32'(busy), 32'd0);

    // Long hold gives one event; unknown code ignored.
    key = 8'h07;
    repeat (50) @(negedge clk);
    key = 8'hFF;
    @(negedge clk);
    chk("hold7_entry", entry, 32'd7);
    chk("hold7_digits", 32'(digits), 32'd1);
    press(8'h20);
    chk("ign_entry", entry, 32'd7);
    chk("ign_digits", 32'(digits), 32'd1);
    press(8'h11);

    // Leading zero is a legal write of 0 to target C.
    press(8'h0C);
    press(8'h00);
    chk("zero_digits", 32'(digits), 32'd1);
    key = 8'h10;
    @(negedge clk);
    key = 8'hFF;
    chk("zero_valid", 32'(wr_valid), 32'd1);
    chk("zero_addr", 32'(wr_addr), 32'd2);
    chk("zero_data", wr_data, 32'd0);
    wr_ready = 1'b1;
    @(negedge clk);
    wr_ready = 1'b0;
    chk("zero_done", 32'(wr_valid), 32'd0);

    // Asynchronous reset mid-COMMIT aborts the write.
    press(8'h05);
    press(8'h05);
    key = 8'h10;
    @(negedge clk);
    key = 8'hFF;
    chk("pre_rst_valid", 32'(wr_valid), 32'd1);
    chk("pre_rst_data", wr_data, 32'd55);
    #2 rst_n = 1'b0;
    #1;
    chk_all_reset("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);
    press(8'h03);
    chk("post_rst_entry", entry, 32'd3);
    chk("post_rst_digits", 32'(digits), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
